// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction-fetch and data requests onto an 8-bit RAM bus, one byte per cycle.
// Optional feature macro MEM_CTRL_IO_STALL_EN: I/O writes (base[17:16] == 2'b11) wait while io_buffer_full.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        flush,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, len_q, len_d;
    logic [31:0] base_q, base_d, wdata_q, wdata_d, asm_q, asm_d;
    logic        own_mem_q, own_mem_d, ack_q, ack_d, busy_q, busy_d;
    logic [31:0] ram_a_q, ram_a_d, if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic        fin, stall;
    logic [31:0] wsh;

`ifdef MEM_CTRL_IO_STALL_EN
    // In IDLE the request address decides; afterwards the latched base does.
    assign stall = io_buffer_full &&
                   (((state_q == IDLE) ? mem_addr[17:16] : base_q[17:16]) == 2'b11);
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign stall     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        own_mem_d   = own_mem_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        fin         = 1'b0;
        wsh         = '0;
        if (rdy_in) begin
            ack_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // ack_q marks the done cycle; requests are only looked at after it.
                    if (!ack_q && mem_req) begin
                        own_mem_d  = 1'b1;
                        base_d     = mem_addr;
                        wdata_d    = mem_wdata;
                        len_d      = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
                        state_d    = mem_we ? WRITE : READ;
                        cnt_d      = 3'd0;
                        asm_d      = '0;
                        ram_a_d    = mem_addr;
                        ram_dout_d = mem_wdata[7:0];
                        ram_wr_d   = mem_we && !stall;
                    end else if (!ack_q && if_req && !flush) begin
                        own_mem_d = 1'b0;
                        base_d    = if_addr;
                        len_d     = 3'd4;
                        state_d   = READ;
                        cnt_d     = 3'd0;
                        asm_d     = '0;
                        ram_a_d   = if_addr;
                    end
                end
                READ: begin
                    if (flush && !own_mem_q) begin
                        state_d = IDLE;
                    end else begin
                        // ram_din carries the byte addressed one cycle earlier.
                        if (cnt_q != 3'd0)
                            asm_d = asm_q | ({24'd0, ram_din} << {cnt_q - 3'd1, 3'b000});
                        if (cnt_q == len_q) begin
                            fin     = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_d < len_q)
                                ram_a_d = base_q + {29'd0, cnt_d};
                        end
                    end
                end
                WRITE: begin
                    // ram_wr_q low means byte cnt still has to go out (stall or rdy gap).
                    if (!ram_wr_q) begin
                        ram_wr_d = !stall;
                    end else if (cnt_q + 3'd1 == len_q) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        wsh        = wdata_q >> {cnt_d, 3'b000};
                        ram_a_d    = base_q + {29'd0, cnt_d};
                        ram_dout_d = wsh[7:0];
                        ram_wr_d   = !stall;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (fin) begin
                ack_d = 1'b1;
                if (own_mem_q) begin
                    mem_done_d = 1'b1;
                    if (state_q == READ)
                        mem_rdata_d = asm_d;
                end else begin
                    if_done_d = 1'b1;
                    if_data_d = asm_d;
                end
            end
            busy_d = (state_d != IDLE) || fin;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            own_mem_q   <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            own_mem_q   <= own_mem_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives mem_ctrl against a byte RAM and checks it with a transaction-level model.
module tb_mem_ctrl;
    logic        clk_in = 1'b0, rst_in, rdy_in, if_req, flush, mem_req, mem_we, io_buffer_full;
    logic [31:0] if_addr, mem_addr, mem_wdata, if_data, mem_rdata, ram_a;
    logic [1:0]  mem_len;
    logic        if_done, mem_done, ram_wr, busy;
    logic [7:0]  ram_din, ram_dout;

    int cyc = 0, checks = 0, errors = 0, last_done = -10;
    logic [7:0]  ram [0:131071];
    logic [7:0]  mdl [0:131071];
    bit          ram_ready = 1'b0;
    logic [31:0] ra_log [0:32767];
    logic        bz_log [0:32767];
    typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t wq[$];
    logic [31:0] last_if_exp = '0, last_mem_exp = '0;
    bit          mem_rd_valid = 1'b1;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37) ^ (i >> 7));
    endfunction

    function automatic int nbytes(logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    // Byte-wide synchronous RAM: ram_din returns the byte addressed in the previous cycle.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (!ram_ready) begin
            for (int i = 0; i < 131072; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (ram_wr) begin
            ram[ram_a[16:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[16:0]];
    end

    always @(negedge clk_in) begin
        ra_log[cyc[14:0]] <= ram_a;
        bz_log[cyc[14:0]] <= busy;
        if (ram_wr) wq.push_back('{cyc, ram_a, ram_dout});
    end

    function automatic logic [31:0] mdl_word(logic [31:0] addr, int n);
        logic [31:0] w, ai;
        w = '0;
        for (int i = 0; i < n; i++) begin
            ai = addr + 32'(i);
            w  = w | (32'(mdl[ai[16:0]]) << (8 * i));
        end
        return w;
    endfunction

    // One transaction; b2b presents it in the done cycle of the previous one.
    task automatic run_txn(input bit fetch, input bit we, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wd, input bit b2b);
        int p, t, n, exp_done, got;
        logic [31:0] exp, ai, wsh;
        bit wr;
        if (!b2b) @(negedge clk_in);
        wr = !fetch && we;
        p = cyc;
        t = (p <= last_done) ? last_done + 1 : p;
        n = fetch ? 4 : nbytes(len);
        exp_done = wr ? t + 1 + n : t + 2 + n;
        exp = mdl_word(addr, n);
        wq.delete();
        if (fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wd;
        end
        got = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (fetch ? if_done : mem_done) begin got = cyc; break; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        last_done = (got < 0) ? cyc : got;
        checks++;
        if (got !== exp_done) begin
            errors++; $display("FAIL done_cycle fetch=%0b we=%0b addr=%h got T+%0d want T+%0d", fetch, we, addr, got - t, exp_done - t);
        end
        checks++;
        if (ram_wr !== 1'b0) begin errors++; $display("FAIL wr_in_done_cycle got %b want 0", ram_wr); end
        checks++;
        if (bz_log[15'(t + 1)] !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_during got T+1=%b done=%b want 1/1", bz_log[15'(t + 1)], busy);
        end
        if (!wr) begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (ra_log[15'(t + 1 + i)] !== addr + 32'(i)) begin
                    errors++; $display("FAIL read_addr byte %0d got %h want %h", i, ra_log[15'(t + 1 + i)], addr + 32'(i));
                end
            end
        end
        if (fetch) begin
            checks++;
            if (if_data !== exp) begin errors++; $display("FAIL if_data addr %h got %h want %h", addr, if_data, exp); end
            last_if_exp = exp;
            if (mem_rd_valid) begin
                checks++;
                if (mem_rdata !== last_mem_exp) begin errors++; $display("FAIL mem_rdata_hold got %h want %h", mem_rdata, last_mem_exp); end
            end
        end else begin
            checks++;
            if (if_data !== last_if_exp) begin errors++; $display("FAIL if_data_hold got %h want %h", if_data, last_if_exp); end
            if (!we) begin
                checks++;
                if (mem_rdata !== exp) begin errors++; $display("FAIL mem_rdata addr %h len %0d got %h want %h", addr, n, mem_rdata, exp); end
                last_mem_exp = exp; mem_rd_valid = 1'b1;
            end else begin
                checks++;
                if (wq.size() !== n) begin errors++; $display("FAIL write_count got %0d want %0d", wq.size(), n); end
                for (int i = 0; i < n; i++) begin
                    ai = addr + 32'(i);
                    wsh = wd >> (8 * i);
                    if (i < wq.size()) begin
                        checks++;
                        if (wq[i].c !== t + 1 + i || wq[i].a !== ai || wq[i].d !== wsh[7:0]) begin
                            errors++; $display("FAIL write_byte %0d got T+%0d %h/%h want T+%0d %h/%h", i, wq[i].c - t, wq[i].a, wq[i].d, 1 + i, ai, wsh[7:0]);
                        end
                    end
                    mdl[ai[16:0]] = wsh[7:0];
                end
                mem_rd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        io_buffer_full = 1'b0; if_addr = '0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({ram_a, ram_dout, ram_wr, if_data, mem_rdata, if_done, mem_done, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got a=%h d=%h wr=%b ifd=%h mrd=%h dn=%b%b busy=%b want all 0",
                               ram_a, ram_dout, ram_wr, if_data, mem_rdata, if_done, mem_done, busy);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_fetch();
        run_txn(1'b0, 1'b1, 32'h100, 2'd2, 32'h9300_0013, 1'b0);
        run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 1'b0);
        checks++;
        if (if_data !== 32'h9300_0013) begin errors++; $display("FAIL fetch_word got %h want 93000013", if_data); end
        @(negedge clk_in);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy); end
    endtask

    task automatic test_arb();
        int t, md, id;
        logic [31:0] mrd, ird, mexp, iexp;
        mexp = mdl_word(32'h2000, 4);
        iexp = mdl_word(32'h440, 4);
        @(negedge clk_in);
        t = cyc; md = -1; id = -1; mrd = '0; ird = '0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_len = 2'd2;
        if_req = 1'b1; if_addr = 32'h440;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (mem_done && md < 0) begin md = cyc; mrd = mem_rdata; mem_req = 1'b0; end
            if (if_done) begin id = cyc; ird = if_data; break; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        last_done = cyc;
        checks++;
        if (md !== t + 6) begin errors++; $display("FAIL arb_mem_done got T+%0d want T+6", md - t); end
        checks++;
        if (id !== t + 13) begin errors++; $display("FAIL arb_if_done got T+%0d want T+13", id - t); end
        checks++;
        if (mrd !== mexp || ird !== iexp) begin
            errors++; $display("FAIL arb_data got %h/%h want %h/%h", mrd, ird, mexp, iexp);
        end
        last_mem_exp = mexp; mem_rd_valid = 1'b1; last_if_exp = iexp;
    endtask

    task automatic test_store_half();
        run_txn(1'b0, 1'b1, 32'h1FFE, 2'd1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk_in);
        checks++;
        if (ram[17'h1FFE] !== 8'hEF || ram[17'h1FFF] !== 8'hBE || ram[17'h1FFD] !== init_byte(32'h1FFD) ||
            ram[17'h2000] !== mdl[17'h2000]) begin
            errors++; $display("FAIL sh_ram got %h %h %h %h want %h EF BE %h", ram[17'h1FFD], ram[17'h1FFE],
                               ram[17'h1FFF], ram[17'h2000], init_byte(32'h1FFD), mdl[17'h2000]);
        end
    endtask

    task automatic test_flush();
        int t, got;
        logic [31:0] exp;
        exp = mdl_word(32'h300, 4);
        @(negedge clk_in);
        t = cyc; got = -1;
        if_req = 1'b1; if_addr = 32'h200;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk_in);
            if (k == 3) begin flush = 1'b1; if_req = 1'b0; end
            if (k == 4) begin
                flush = 1'b0;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy got %b want 0", busy); end
            end
            if (k == 5) begin if_req = 1'b1; if_addr = 32'h300; end
            if (if_done) begin got = k; break; end
        end
        if_req = 1'b0;
        checks++;
        if (got !== 11 || if_data !== exp) begin
            errors++; $display("FAIL flush_refetch got T+%0d %h want T+11 %h", got, if_data, exp);
        end
        last_if_exp = exp;
        // flush in IDLE drops that cycle's fetch request only
        @(negedge clk_in);
        t = cyc; got = -1;
        if_req = 1'b1; if_addr = 32'h500; flush = 1'b1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk_in);
            flush = 1'b0;
            if (if_done) begin got = k; break; end
        end
        if_req = 1'b0;
        checks++;
        if (got !== 7) begin errors++; $display("FAIL flush_idle_fetch got T+%0d want T+7", got); end
        last_if_exp = mdl_word(32'h500, 4);
        // data accesses ignore flush
        exp = mdl_word(32'h40, 4);
        @(negedge clk_in);
        got = -1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_len = 2'd3;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk_in);
            flush = (k == 3);
            if (mem_done) begin got = k; break; end
        end
        mem_req = 1'b0; flush = 1'b0;
        checks++;
        if (got !== 6 || mem_rdata !== exp) begin
            errors++; $display("FAIL flush_mem got T+%0d %h want T+6 %h", got, mem_rdata, exp);
        end
        last_mem_exp = exp; mem_rd_valid = 1'b1;
        last_done = cyc;
    endtask

    task automatic test_rdy();
        int got;
        logic [31:0] exp;
        exp = {24'd0, mdl[17'h30]};
        @(negedge clk_in);
        got = -1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30; mem_len = 2'd0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk_in);
            if (k == 2) rdy_in = 1'b0;
            if (k == 5) rdy_in = 1'b1;
            if (k <= 5) begin
                checks++;
                if (ram_a !== 32'h30) begin errors++; $display("FAIL rdy_addr_hold T+%0d got %h want 00000030", k, ram_a); end
            end
            if (mem_done) begin got = k; break; end
        end
        mem_req = 1'b0; rdy_in = 1'b1;
        checks++;
        if (got !== 6 || mem_rdata !== exp) begin
            errors++; $display("FAIL rdy_lb got T+%0d %h want T+6 %h", got, mem_rdata, exp);
        end
        last_mem_exp = exp; mem_rd_valid = 1'b1;
        last_done = cyc;
    endtask

    task automatic io_store(input logic [31:0] addr, input logic [7:0] d, input int full_cycles,
                            input int want_wr, input int want_done);
        int t, got;
        @(negedge clk_in);
        t = cyc; got = -1;
        wq.delete();
        io_buffer_full = 1'b1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = addr; mem_len = 2'd0; mem_wdata = {24'hABCDEF, d};
        for (int k = 1; k < 40; k++) begin
            @(negedge clk_in);
            if (k == full_cycles) io_buffer_full = 1'b0;
            if (mem_done) begin got = k; break; end
        end
        mem_req = 1'b0; io_buffer_full = 1'b0;
        checks++;
        if (got !== want_done) begin errors++; $display("FAIL io_done addr %h got T+%0d want T+%0d", addr, got, want_done); end
        checks++;
        if (wq.size() !== 1 || wq[0].c !== t + want_wr || wq[0].a !== addr || wq[0].d !== d) begin
            errors++; $display("FAIL io_write addr %h got n=%0d T+%0d want n=1 T+%0d data %h", addr, wq.size(),
                               (wq.size() > 0) ? wq[0].c - t : -1, want_wr, d);
        end
        mdl[addr[16:0]] = d;
        mem_rd_valid = 1'b0;
        last_done = cyc;
    endtask

    task automatic test_io();
`ifdef MEM_CTRL_IO_STALL_EN
        io_store(32'h0003_0000, 8'h5A, 2, 3, 4);
`else
        io_store(32'h0003_0000, 8'h5A, 2, 1, 2);
`endif
        // outside the I/O window a full buffer never stalls
        io_store(32'h0002_0004, 8'hC3, 40, 1, 2);
    endtask

    task automatic test_back_to_back();
        int kind;
        bit b2b;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            b2b  = (i > 0) && ($urandom_range(0, 1) == 1);
            run_txn(kind == 0, kind == 2, 32'($urandom_range(0, 32'hFFF0)), 2'($urandom_range(0, 3)), $urandom, b2b);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk_in);
        seen = 0;
        if_req = 1'b1; if_addr = 32'h600;
        for (int k = 1; k < 14; k++) begin
            @(negedge clk_in);
            if (k == 3) begin rst_in = 1'b1; if_req = 1'b0; end
            if (k == 4) begin
                rst_in = 1'b0;
                checks++;
                if ({ram_a, ram_dout, ram_wr, if_data, mem_rdata, if_done, mem_done, busy} !== '0) begin
                    errors++; $display("FAIL midreset_outputs got a=%h ifd=%h mrd=%h busy=%b want 0", ram_a, if_data, mem_rdata, busy);
                end
            end
            if (if_done) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", seen); end
        last_if_exp = '0; last_mem_exp = '0; mem_rd_valid = 1'b1;
        run_txn(1'b1, 1'b0, 32'h604, 2'd2, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mdl[i] = init_byte(i);
        test_reset();
        test_fetch();
        test_arb();
        test_store_half();
        test_flush();
        test_rdy();
        test_io();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d reached without finishing", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between the instruction-fetch stage and the data-memory stage. Owns the 8-bit RAM bus and serialises 1/2/4-byte reads and writes into byte cycles, returning one assembled 32-bit word per transaction. Data accesses take priority over fetches. A pipeline flush aborts an in-flight fetch.

## Interface
- No parameters.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global enable; low freezes all state.
- `if_req` in 1: fetch request, held until `if_done`.
- `if_addr` in 32: fetch byte address.
- `if_done` out 1: one-cycle pulse, `if_data` valid.
- `if_data` out 32: fetched word.
- `flush` in 1: abort pending or in-flight fetch.
- `mem_req` in 1: data request, held until `mem_done`.
- `mem_we` in 1: 1 selects write, 0 selects read.
- `mem_addr` in 32: data byte address.
- `mem_len` in 2: 0 is 1 byte, 1 is 2 bytes, 2 or 3 is 4 bytes.
- `mem_wdata` in 32: write data; byte i is `[8i+7:8i]`.
- `mem_done` out 1: one-cycle pulse, access complete.
- `mem_rdata` out 32: read data, zero-extended.
- `ram_din` in 8: RAM read byte for the address driven the previous cycle.
- `ram_dout` out 8: RAM write byte.
- `ram_a` out 32: RAM address.
- `ram_wr` out 1: 1 is write, 0 is read.
- `io_buffer_full` in 1: I/O write buffer full (see Configuration).
- `busy` out 1: high when state is not IDLE.

## Operation
- States: IDLE, READ, WRITE. A byte counter `cnt` runs 0..4. Latched fields: base address, length n (1/2/4), write data, and owner (IF or MEM).
- Arbitration in IDLE:
  - `mem_req` wins over `if_req`.
  - An accepted transaction is never preempted.
  - If `flush` is high, `if_req` is ignored in that cycle.
- Byte order is little-endian: byte at base+i maps to bits `[8i+7:8i]`.
- Fetch is always a 4-byte read.
- READ:
  - Drive `ram_a` = base+cnt for cnt < n.
  - Capture `ram_din` into byte cnt-1 for cnt ≥ 1.
  - Finish after byte n-1 is captured.
- WRITE:
  - Drive `ram_a` = base+cnt, `ram_dout` = byte cnt, and `ram_wr` = 1.
  - Finish after byte n-1 is driven.
- At finish, pulse the owner's done output for one cycle and return to IDLE. `ram_wr` = 0 in the done cycle.
- Requests are sampled again from the cycle after the done pulse. The requester drops `req` in the done cycle or presents the next request.
- `flush` while the owner is IF: the next state is IDLE, captured bytes are discarded, and no `if_done` is issued.
- `flush` while the owner is MEM is ignored; stores must complete.
- `rdy_in` = 0: state, counter and latches hold. `ram_wr` is forced to 0, and `if_done`/`mem_done` are held low; a pending done pulse is issued once `rdy_in` returns.
- Reset values:
  - `ram_a`, `ram_dout`, `ram_wr`, `if_data`, `mem_rdata` = 0.
  - `if_done`, `mem_done`, `busy` = 0.
  - State is IDLE.
  - Reset mid-transaction abandons it immediately; no done pulse is issued.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle T:
  - Read of n bytes: `ram_a` = base+i at T+1+i. Byte i is on `ram_din` at T+2+i. Done and data are valid at T+2+n (word read: T+6).
  - Write of n bytes: `ram_wr` = 1 with `ram_a` = base+i at T+1+i. Done at T+1+n (word write: T+5).
- Back-to-back transactions: the earliest next address cycle is done+2.
- `busy` rises at T+1 and falls in the cycle after done.
- `if_data`/`mem_rdata` hold their value until the next completion of the same owner.

## Configuration
- Macro: `MEM_CTRL_IO_STALL_EN`.
- Defined:
  - Applies to a WRITE with base `[17:16]` == 2'b11.
  - Each byte cycle with `io_buffer_full` = 1 stalls: `ram_wr` = 0 and `cnt` holds.
  - The byte is issued in the first cycle with `io_buffer_full` = 0, and done is delayed by the stall count.
- Undefined: `io_buffer_full` is ignored, and I/O writes use normal timing.

## Test plan
- Fetch, `if_addr` = 0x100, RAM 0x100..0x103 = 13,00,00,93:
  - `ram_a` = 0x100..0x103 at T+1..T+4.
  - `if_done` at T+6 with `if_data` = 0x93000013.
- `if_req` and `mem_req` (lw 0x2000) in the same cycle: `mem_done` issues first at T+6, then fetch starts at T+7 and `if_done` follows at T+13.
- sh, 0x1FFE, `mem_wdata` = 0xDEADBEEF:
  - `ram_wr` = 1 at 0x1FFE/EF, then 0x1FFF/BE.
  - `mem_done` at T+3, and no write in the done cycle.
- `flush` at T+3 of a fetch: state IDLE at T+4 and no `if_done`; a new fetch accepted at T+5 completes normally.
- lb 0x30 with `rdy_in` low for 3 cycles at T+2: `ram_a` holds; `mem_done` at T+6 with `mem_rdata` = zero-extended byte.
- `MEM_CTRL_IO_STALL_EN` defined, sb 0x30000 with `io_buffer_full` high for 2 cycles:
  - Byte written at T+3 and `mem_done` at T+4.
  - With the macro undefined: byte written at T+1 and `mem_done` at T+2.
